// File: rtl/axis_input_join_pkg.sv
// Shared defaults and tuser layout for the AXI-Stream input join.
// m_axis_tuser is packed as {weights_user_gated, pixel0_user}.
package axis_input_join_pkg;

    localparam int DEF_PIXEL_STREAMS   = 2;
    localparam int DEF_UNITS           = 8;
    localparam int DEF_WORD_WIDTH      = 8;
    localparam int DEF_CORES           = 4;
    localparam int DEF_KERNEL_W_MAX    = 3;
    localparam int DEF_TUSER_WIDTH_PIX = 4;
    localparam int DEF_TUSER_WIDTH_W   = 8;
    localparam int DEF_COUNT_WIDTH     = 16;

    localparam logic [DEF_TUSER_WIDTH_W-1:0] DEF_GATE_MASK = 8'b0011_1000;

    // Pixel-0 user sits at the bottom of m_axis_tuser; weight user follows it.
    localparam int TUSER_PIX_LSB = 0;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry skid FIFO with a registered s_ready that depends only on occupancy.
// Payload is an opaque vector; the caller packs {last, user, data}.
module axis_skid_fifo2
    import axis_input_join_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_payload,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_payload,
    input  logic             pop
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             push;
    logic             do_pop;

    assign push   = s_valid && s_ready;
    assign do_pop = pop && m_valid;

    always_comb begin
        count_next = count + {1'b0, push} - {1'b0, do_pop};
    end

    // s_ready is computed from the next occupancy so it never sees m_axis_tready combinationally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            count   <= count_next;
            s_ready <= (count_next < 2'(SKID_DEPTH));
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= s_payload;
        end
    end

    assign m_valid   = (count != 2'd0);
    assign m_payload = mem[rd_ptr];

endmodule

// File: rtl/axis_input_join.sv
// Joins PIXEL_STREAMS pixel streams and one weight stream into a single registered
// output beat; every input is decoupled by its own two-entry skid FIFO.
module axis_input_join
    import axis_input_join_pkg::*;
#(
    parameter int PIXEL_STREAMS   = DEF_PIXEL_STREAMS,
    parameter int UNITS           = DEF_UNITS,
    parameter int WORD_WIDTH      = DEF_WORD_WIDTH,
    parameter int CORES           = DEF_CORES,
    parameter int KERNEL_W_MAX    = DEF_KERNEL_W_MAX,
    parameter int TUSER_WIDTH_PIX = DEF_TUSER_WIDTH_PIX,
    parameter int TUSER_WIDTH_W   = DEF_TUSER_WIDTH_W,
    parameter logic [TUSER_WIDTH_W-1:0] GATE_MASK = DEF_GATE_MASK,
    parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
    input  logic                                          aclk,
    input  logic                                          aresetn,
    input  logic [PIXEL_STREAMS-1:0]                      s_axis_pixels_tvalid,
    output logic [PIXEL_STREAMS-1:0]                      s_axis_pixels_tready,
    input  logic [PIXEL_STREAMS-1:0]                      s_axis_pixels_tlast,
    input  logic [PIXEL_STREAMS*UNITS*WORD_WIDTH-1:0]     s_axis_pixels_tdata,
    input  logic [PIXEL_STREAMS*TUSER_WIDTH_PIX-1:0]      s_axis_pixels_tuser,
    input  logic                                          s_axis_weights_tvalid,
    output logic                                          s_axis_weights_tready,
    input  logic                                          s_axis_weights_tlast,
    input  logic [CORES*KERNEL_W_MAX*WORD_WIDTH-1:0]      s_axis_weights_tdata,
    input  logic [TUSER_WIDTH_W-1:0]                      s_axis_weights_tuser,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic                                          m_axis_tlast,
    output logic [PIXEL_STREAMS*UNITS*WORD_WIDTH-1:0]     m_axis_pixels_tdata,
    output logic [CORES*KERNEL_W_MAX*WORD_WIDTH-1:0]      m_axis_weights_tdata,
    output logic [TUSER_WIDTH_W+TUSER_WIDTH_PIX-1:0]      m_axis_tuser,
    output logic                                          err_tlast_mismatch,
    output logic [COUNT_WIDTH-1:0]                        beat_count
);

    localparam int PIX_W       = UNITS * WORD_WIDTH;
    localparam int WGT_W       = CORES * KERNEL_W_MAX * WORD_WIDTH;
    localparam int PIX_FW      = PIX_W + TUSER_WIDTH_PIX + 1;
    localparam int WGT_FW      = WGT_W + TUSER_WIDTH_W + 1;
    localparam int TUSER_W_LSB = TUSER_PIX_LSB + TUSER_WIDTH_PIX;

    logic [PIXEL_STREAMS-1:0]       pix_valid;
    logic [PIXEL_STREAMS-1:0]       pix_last;
    logic [PIXEL_STREAMS*PIX_W-1:0] pix_data;
    logic [TUSER_WIDTH_PIX-1:0]     pix0_user;

    logic [WGT_FW-1:0]              wgt_head;
    logic                           wgt_valid;
    logic                           join_fire;
    logic                           out_handshake;

    logic                           out_valid;
    logic                           out_last;
    logic [PIXEL_STREAMS*PIX_W-1:0] out_pix;
    logic [WGT_W-1:0]               out_wgt;
    logic [TUSER_WIDTH_W-1:0]       out_wuser;
    logic [TUSER_WIDTH_PIX-1:0]     out_puser;

    for (genvar k = 0; k < PIXEL_STREAMS; k++) begin : g_pix
        logic [PIX_FW-1:0] head;

        axis_skid_fifo2 #(.WIDTH(PIX_FW)) u_fifo (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .s_valid   (s_axis_pixels_tvalid[k]),
            .s_ready   (s_axis_pixels_tready[k]),
            .s_payload ({s_axis_pixels_tlast[k],
                         s_axis_pixels_tuser[k*TUSER_WIDTH_PIX +: TUSER_WIDTH_PIX],
                         s_axis_pixels_tdata[k*PIX_W +: PIX_W]}),
            .m_valid   (pix_valid[k]),
            .m_payload (head),
            .pop       (join_fire)
        );

        assign pix_data[k*PIX_W +: PIX_W] = head[PIX_W-1:0];
        assign pix_last[k]                = head[PIX_FW-1];
        if (k == 0) begin : g_user0
            assign pix0_user = head[PIX_W +: TUSER_WIDTH_PIX];
        end
    end

    axis_skid_fifo2 #(.WIDTH(WGT_FW)) u_wgt_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_valid   (s_axis_weights_tvalid),
        .s_ready   (s_axis_weights_tready),
        .s_payload ({s_axis_weights_tlast, s_axis_weights_tuser, s_axis_weights_tdata}),
        .m_valid   (wgt_valid),
        .m_payload (wgt_head),
        .pop       (join_fire)
    );

    // All heads leave together; a lone head is never popped.
    assign out_handshake = out_valid && m_axis_tready;
    assign join_fire     = (&pix_valid) && wgt_valid && (!out_valid || m_axis_tready);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid          <= 1'b0;
            out_last           <= 1'b0;
            out_pix            <= '0;
            out_wgt            <= '0;
            out_wuser          <= '0;
            out_puser          <= '0;
            err_tlast_mismatch <= 1'b0;
            beat_count         <= '0;
        end else begin
            if (join_fire) begin
                out_valid <= 1'b1;
                out_last  <= wgt_head[WGT_FW-1];
                out_pix   <= pix_data;
                out_wgt   <= wgt_head[WGT_W-1:0];
                out_wuser <= wgt_head[WGT_W +: TUSER_WIDTH_W];
                out_puser <= pix0_user;
                if (pix_last != {PIXEL_STREAMS{wgt_head[WGT_FW-1]}}) begin
                    err_tlast_mismatch <= 1'b1;
                end
            end else if (out_handshake) begin
                out_valid <= 1'b0;
            end
            if (out_handshake) begin
                beat_count <= out_last ? '0 : beat_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign m_axis_tvalid        = out_valid;
    assign m_axis_tlast         = out_last;
    assign m_axis_pixels_tdata  = out_pix;
    assign m_axis_weights_tdata = out_wgt;
    assign m_axis_tuser[TUSER_PIX_LSB +: TUSER_WIDTH_PIX] = out_puser;
    assign m_axis_tuser[TUSER_W_LSB +: TUSER_WIDTH_W] =
        out_wuser & (~GATE_MASK | {TUSER_WIDTH_W{out_valid}});

endmodule

// File: tb/tb_axis_input_join.sv
// Self-checking bench for axis_input_join: per-source drivers fed from queues,
// an output scoreboard, and one task per scenario.
module tb_axis_input_join;

  localparam int PS    = 2;
  localparam int UNITS = 8;
  localparam int WW    = 8;
  localparam int CORES = 4;
  localparam int KW    = 3;
  localparam int TUP   = 4;
  localparam int TUW   = 8;
  localparam int CW    = 16;
  localparam int PD    = UNITS * WW;
  localparam int WD    = CORES * KW * WW;
  localparam int PBW   = PD + TUP + 1;
  localparam int WBW   = WD + TUW + 1;
  localparam int OW    = 1 + TUW + TUP + WD + PS * PD;

  logic              aclk;
  logic              aresetn;
  logic [PS-1:0]     s_axis_pixels_tvalid;
  logic [PS-1:0]     s_axis_pixels_tready;
  logic [PS-1:0]     s_axis_pixels_tlast;
  logic [PS*PD-1:0]  s_axis_pixels_tdata;
  logic [PS*TUP-1:0] s_axis_pixels_tuser;
  logic              s_axis_weights_tvalid;
  logic              s_axis_weights_tready;
  logic              s_axis_weights_tlast;
  logic [WD-1:0]     s_axis_weights_tdata;
  logic [TUW-1:0]    s_axis_weights_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [PS*PD-1:0]  m_axis_pixels_tdata;
  logic [WD-1:0]     m_axis_weights_tdata;
  logic [TUW+TUP-1:0] m_axis_tuser;
  logic              err_tlast_mismatch;
  logic [CW-1:0]     beat_count;

  axis_input_join #(
    .PIXEL_STREAMS   (PS),
    .UNITS           (UNITS),
    .WORD_WIDTH      (WW),
    .CORES           (CORES),
    .KERNEL_W_MAX    (KW),
    .TUSER_WIDTH_PIX (TUP),
    .TUSER_WIDTH_W   (TUW),
    .GATE_MASK       (8'b0011_1000),
    .COUNT_WIDTH     (CW)
  ) dut (
    .aclk                  (aclk),
    .aresetn               (aresetn),
    .s_axis_pixels_tvalid  (s_axis_pixels_tvalid),
    .s_axis_pixels_tready  (s_axis_pixels_tready),
    .s_axis_pixels_tlast   (s_axis_pixels_tlast),
    .s_axis_pixels_tdata   (s_axis_pixels_tdata),
    .s_axis_pixels_tuser   (s_axis_pixels_tuser),
    .s_axis_weights_tvalid (s_axis_weights_tvalid),
    .s_axis_weights_tready (s_axis_weights_tready),
    .s_axis_weights_tlast  (s_axis_weights_tlast),
    .s_axis_weights_tdata  (s_axis_weights_tdata),
    .s_axis_weights_tuser  (s_axis_weights_tuser),
    .m_axis_tvalid         (m_axis_tvalid),
    .m_axis_tready         (m_axis_tready),
    .m_axis_tlast          (m_axis_tlast),
    .m_axis_pixels_tdata   (m_axis_pixels_tdata),
    .m_axis_weights_tdata  (m_axis_weights_tdata),
    .m_axis_tuser          (m_axis_tuser),
    .err_tlast_mismatch    (err_tlast_mismatch),
    .beat_count            (beat_count)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus queues / scoreboard ----------------
  logic [PBW-1:0] pix_q[PS][$];
  logic [WBW-1:0] w_q[$];
  logic [OW-1:0]  exp_q[$];
  int pix_start[PS];
  int w_start = 0;
  int pix_acc[PS];
  int w_acc = 0;
  int n_out = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Source drivers: decide handshake at negedge, advance after the posedge.
  initial begin
    logic [PS-1:0] fire_p;
    logic          fire_w;
    logic [PBW-1:0] pb;
    logic [WBW-1:0] wb;
    s_axis_pixels_tvalid  = '0;
    s_axis_pixels_tlast   = '0;
    s_axis_pixels_tdata   = '0;
    s_axis_pixels_tuser   = '0;
    s_axis_weights_tvalid = 1'b0;
    s_axis_weights_tlast  = 1'b0;
    s_axis_weights_tdata  = '0;
    s_axis_weights_tuser  = '0;
    for (int k = 0; k < PS; k++) begin
      pix_start[k] = 0;
      pix_acc[k]   = 0;
    end
    forever begin
      @(negedge aclk);
      fire_p = s_axis_pixels_tvalid & s_axis_pixels_tready & {PS{aresetn}};
      fire_w = s_axis_weights_tvalid && s_axis_weights_tready && aresetn;
      @(posedge aclk);
      #1;
      for (int k = 0; k < PS; k++) begin
        if (fire_p[k] && pix_q[k].size() > 0) begin
          void'(pix_q[k].pop_front());
          pix_acc[k]++;
        end
        if (pix_q[k].size() > 0 && cyc >= pix_start[k]) begin
          pb = pix_q[k][0];
          s_axis_pixels_tvalid[k]          = 1'b1;
          s_axis_pixels_tdata[k*PD +: PD]  = pb[PD-1:0];
          s_axis_pixels_tuser[k*TUP +: TUP] = pb[PD +: TUP];
          s_axis_pixels_tlast[k]           = pb[PBW-1];
        end else begin
          s_axis_pixels_tvalid[k] = 1'b0;
        end
      end
      if (fire_w && w_q.size() > 0) begin
        void'(w_q.pop_front());
        w_acc++;
      end
      if (w_q.size() > 0 && cyc >= w_start) begin
        wb = w_q[0];
        s_axis_weights_tvalid = 1'b1;
        s_axis_weights_tdata  = wb[WD-1:0];
        s_axis_weights_tuser  = wb[WD +: TUW];
        s_axis_weights_tlast  = wb[WBW-1];
      end else begin
        s_axis_weights_tvalid = 1'b0;
      end
    end
  end

  // Scoreboard: every output handshake must match the oldest expected beat.
  initial begin
    logic [OW-1:0] got;
    logic [OW-1:0] exp;
    forever begin
      @(negedge aclk);
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
        got = {m_axis_tlast, m_axis_tuser, m_axis_weights_tdata, m_axis_pixels_tdata};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_extra: unexpected beat %h, required none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_bad++;
            $display("FAIL scoreboard_beat: got %h required %h", got, exp);
          end
        end
        n_out++;
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [WD-1:0] rnd_w();
    logic [WD-1:0] r = '0;
    for (int i = 0; i < WD; i += 16) r = (r << 16) | WD'($urandom_range(0, 65535));
    return r;
  endfunction

  function automatic logic [PD-1:0] rnd_p();
    logic [PD-1:0] r = '0;
    for (int i = 0; i < PD; i += 16) r = (r << 16) | PD'($urandom_range(0, 65535));
    return r;
  endfunction

  task automatic push_beat(input logic [PS-1:0] plast, input logic wlast, input logic [TUW-1:0] wuser);
    logic [PS*PD-1:0] pcat;
    logic [PD-1:0]    pd;
    logic [TUP-1:0]   pu;
    logic [TUP-1:0]   pu0;
    logic [WD-1:0]    wd;
    pcat = '0;
    pu0  = '0;
    for (int k = 0; k < PS; k++) begin
      pd = rnd_p();
      pu = TUP'($urandom_range(0, 15));
      if (k == 0) pu0 = pu;
      pix_q[k].push_back({plast[k], pu, pd});
      pcat[k*PD +: PD] = pd;
    end
    wd = rnd_w();
    w_q.push_back({wlast, wuser, wd});
    exp_q.push_back({wlast, wuser, pu0, wd, pcat});
  endtask

  task automatic flush_queues();
    for (int k = 0; k < PS; k++) pix_q[k].delete();
    w_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    m_axis_tready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    flush_queues();
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge aclk);
      t++;
    end
    @(posedge aclk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d beats still expected, required 0", name, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    m_axis_tready = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    n_cmp++;
    if ({s_axis_pixels_tready, s_axis_weights_tready, m_axis_tvalid, m_axis_tlast, err_tlast_mismatch} !== '0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 0", {s_axis_pixels_tready, s_axis_weights_tready, m_axis_tvalid, m_axis_tlast, err_tlast_mismatch});
    end
    n_cmp++;
    if ({m_axis_pixels_tdata, m_axis_weights_tdata, m_axis_tuser, beat_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got nonzero data/user/count, required 0");
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    n_cmp++;
    if ({s_axis_pixels_tready, s_axis_weights_tready} !== '0) begin
      n_bad++;
      $display("FAIL reset_ready_early: got %b required 0", {s_axis_pixels_tready, s_axis_weights_tready});
    end
    @(negedge aclk);
    n_cmp++;
    if ({s_axis_pixels_tready, s_axis_weights_tready} !== {(PS+1){1'b1}}) begin
      n_bad++;
      $display("FAIL reset_ready_rise: got %b required all ones", {s_axis_pixels_tready, s_axis_weights_tready});
    end
  endtask

  task automatic test_aligned();
    bit found = 0;
    for (int k = 0; k < PS; k++) pix_start[k] = 0;
    w_start = 0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) push_beat({PS{i == 9}}, i == 9, TUW'($urandom_range(0, 255)));
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge aclk);
      found = s_axis_weights_tvalid && s_axis_weights_tready &&
              ((s_axis_pixels_tvalid & s_axis_pixels_tready) == {PS{1'b1}});
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL aligned_accept: no joint acceptance within 50 cycles");
    end
    @(negedge aclk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL aligned_latency1: m_axis_tvalid got %b required 0", m_axis_tvalid);
    end
    @(negedge aclk);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (m_axis_tvalid !== 1'b1 || beat_count !== CW'(i) || m_axis_tlast !== (i == 9)) begin
        n_bad++;
        $display("FAIL aligned_beat%0d: valid %b count %0d last %b, required 1 %0d %b",
                 i, m_axis_tvalid, beat_count, m_axis_tlast, i, (i == 9));
      end
      @(negedge aclk);
    end
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || beat_count !== '0) begin
      n_bad++;
      $display("FAIL aligned_end: valid %b count %0d, required 0 0", m_axis_tvalid, beat_count);
    end
    wait_drain("aligned");
  endtask

  task automatic test_skew();
    bit found = 0;
    int base;
    base = pix_acc[0];
    for (int k = 0; k < PS; k++) pix_start[k] = cyc + 1;
    w_start = cyc + 6;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) push_beat({PS{i == 3}}, i == 3, TUW'($urandom_range(0, 255)));
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge aclk);
      found = s_axis_weights_tvalid && s_axis_weights_tready;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL skew_accept: weight beat not accepted within 50 cycles");
    end
    n_cmp++;
    if (s_axis_pixels_tready !== '0 || pix_acc[0] - base != 2) begin
      n_bad++;
      $display("FAIL skew_pix_stall: tready %b accepted %0d, required 0 and 2", s_axis_pixels_tready, pix_acc[0] - base);
    end
    @(negedge aclk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL skew_join_early: m_axis_tvalid got %b required 0", m_axis_tvalid);
    end
    @(negedge aclk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1) begin
      n_bad++;
      $display("FAIL skew_join: m_axis_tvalid got %b required 1", m_axis_tvalid);
    end
    wait_drain("skew");
    for (int k = 0; k < PS; k++) pix_start[k] = 0;
    w_start = 0;
  endtask

  task automatic test_backpressure();
    int base;
    int t = 0;
    logic [OW+1:0] snap;
    logic [OW+1:0] now;
    m_axis_tready = 1'b1;
    base = n_out;
    for (int i = 0; i < 12; i++) push_beat({PS{i == 11}}, i == 11, TUW'($urandom_range(0, 255)));
    while (n_out < base + 3 && t < 100) begin
      @(negedge aclk);
      t++;
    end
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b0;
    @(negedge aclk);
    snap = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_weights_tdata, m_axis_pixels_tdata, beat_count == CW'(3)};
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || beat_count !== CW'(3)) begin
      n_bad++;
      $display("FAIL bp_stall_start: valid %b count %0d, required 1 3", m_axis_tvalid, beat_count);
    end
    repeat (7) begin
      @(negedge aclk);
      now = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_weights_tdata, m_axis_pixels_tdata, beat_count == CW'(3)};
      n_cmp++;
      if (now !== snap) begin
        n_bad++;
        $display("FAIL bp_hold: output changed %h, required %h", now, snap);
      end
    end
    n_cmp++;
    if ({s_axis_pixels_tready, s_axis_weights_tready} !== '0) begin
      n_bad++;
      $display("FAIL bp_inputs_full: tready %b required 0", {s_axis_pixels_tready, s_axis_weights_tready});
    end
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    wait_drain("bp");
    n_cmp++;
    if (beat_count !== '0) begin
      n_bad++;
      $display("FAIL bp_count_end: got %0d required 0", beat_count);
    end
  endtask

  task automatic test_tlast_mismatch();
    logic [PS-1:0] pl;
    bit seen2 = 0;
    bit seen3 = 0;
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pl = {PS{i == 3}};
      if (PS > 1) pl[PS-1] = (i == 2);
      push_beat(pl, i == 3, TUW'($urandom_range(0, 255)));
    end
    for (int t = 0; t < 60 && !seen3; t++) begin
      @(negedge aclk);
      if (m_axis_tvalid && beat_count == CW'(1)) begin
        seen2 = 1;
        n_cmp++;
        if (err_tlast_mismatch !== 1'b0) begin
          n_bad++;
          $display("FAIL tlast_err_early: got %b required 0", err_tlast_mismatch);
        end
      end
      if (m_axis_tvalid && beat_count == CW'(2)) begin
        seen3 = 1;
        n_cmp++;
        if (err_tlast_mismatch !== 1'b1) begin
          n_bad++;
          $display("FAIL tlast_err_set: got %b required 1", err_tlast_mismatch);
        end
      end
    end
    n_cmp++;
    if (!(seen2 && seen3)) begin
      n_bad++;
      $display("FAIL tlast_beats_seen: beat2 %0d beat3 %0d, required 1 1", seen2, seen3);
    end
    wait_drain("tlast");
    repeat (5) @(negedge aclk);
    n_cmp++;
    if (err_tlast_mismatch !== 1'b1 || beat_count !== '0) begin
      n_bad++;
      $display("FAIL tlast_err_sticky: err %b count %0d, required 1 0", err_tlast_mismatch, beat_count);
    end
  endtask

  task automatic test_gate_reset();
    int t = 0;
    int base;
    do_reset();
    m_axis_tready = 1'b0;
    push_beat({PS{1'b1}}, 1'b1, 8'hFF);
    while (!m_axis_tvalid && t < 50) begin
      @(negedge aclk);
      t++;
    end
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tuser[TUP +: TUW] !== 8'hFF) begin
      n_bad++;
      $display("FAIL gate_valid: valid %b wuser %h, required 1 ff", m_axis_tvalid, m_axis_tuser[TUP +: TUW]);
    end
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b0;
    @(negedge aclk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tuser[TUP +: TUW] !== 8'hC7) begin
      n_bad++;
      $display("FAIL gate_idle: valid %b wuser %h, required 0 c7", m_axis_tvalid, m_axis_tuser[TUP +: TUW]);
    end
    // Mid-packet reset with beats buffered everywhere.
    base = n_out;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) push_beat({PS{i == 5}}, i == 5, TUW'($urandom_range(0, 255)));
    t = 0;
    while (n_out < base + 2 && t < 50) begin
      @(negedge aclk);
      t++;
    end
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge aclk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || beat_count !== CW'(2)) begin
      n_bad++;
      $display("FAIL midrst_before: valid %b count %0d, required 1 2", m_axis_tvalid, beat_count);
    end
    aresetn = 1'b0;
    flush_queues();
    #1;
    n_cmp++;
    if ({s_axis_pixels_tready, s_axis_weights_tready, m_axis_tvalid, m_axis_tlast, err_tlast_mismatch} !== '0 ||
        {m_axis_pixels_tdata, m_axis_weights_tdata, m_axis_tuser, beat_count} !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs: flags %b count %0d, required all 0",
               {s_axis_pixels_tready, s_axis_weights_tready, m_axis_tvalid, m_axis_tlast, err_tlast_mismatch}, beat_count);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    n_cmp++;
    if ({s_axis_pixels_tready, s_axis_weights_tready} !== {(PS+1){1'b1}}) begin
      n_bad++;
      $display("FAIL midrst_ready: got %b required all ones", {s_axis_pixels_tready, s_axis_weights_tready});
    end
    repeat (4) begin
      @(negedge aclk);
      n_cmp++;
      if (m_axis_tvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL midrst_empty: m_axis_tvalid got %b required 0", m_axis_tvalid);
      end
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) push_beat({PS{i == 2}}, i == 2, TUW'($urandom_range(0, 255)));
    wait_drain("midrst");
    n_cmp++;
    if (beat_count !== '0 || err_tlast_mismatch !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_end: count %0d err %b, required 0 0", beat_count, err_tlast_mismatch);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    test_aligned();
    test_skew();
    test_backpressure();
    test_tlast_mismatch();
    test_gate_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
